// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between an issuing controller and the sequential multiply/divide unit.
interface muldiv_seq_if #(parameter int WIDTH = 32);
  logic valid;
  logic [2:0] op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic ready;
  logic [WIDTH-1:0] result;
  logic div_by_zero;
  logic busy;
  modport master(output valid, op, a, b, input ready, result, div_by_zero, busy);
  modport slave(input valid, op, a, b, output ready, result, div_by_zero, busy);
endinterface

// File: rtl/muldiv_seq.sv
// muldiv_seq: RV32M multiply/divide unit, shift-add multiply and radix-2 restoring divide on operand magnitudes.
module muldiv_seq #(
  parameter int WIDTH = 32,
  parameter int MUL_STEP = 1,
  parameter int EARLY_OUT = 1
) (
  input logic clk,
  input logic resetn,
  muldiv_seq_if.slave bus
);
  localparam int W = WIDTH;
  localparam int CW = $clog2(WIDTH) + 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE, HOLD} state_t;
  state_t state;
  logic [2:0] op_r;
  logic [W-1:0] a_r, m, ma, mb, dv, fin, result;
  logic [2*W-1:0] p, p_nx, prod;
  logic [W+MUL_STEP-1:0] msum;
  logic [W:0] r2, diff;
  logic [CW-1:0] cnt;
  logic neg, dz, sa, sb, is_div, zero, ovf, early, last, ready, busy, div_by_zero;
  assign bus.ready = ready;
  assign bus.busy = busy;
  assign bus.result = result;
  assign bus.div_by_zero = div_by_zero;
  always_comb begin
    is_div = bus.op[2];
    sa = bus.a[W-1] & (is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01 || bus.op[1:0] == 2'b10));
    sb = bus.b[W-1] & (is_div ? ~bus.op[0] : (bus.op[1:0] == 2'b01));
    ma = sa ? -bus.a : bus.a;
    mb = sb ? -bus.b : bus.b;
    zero = is_div && bus.b == '0;
    ovf = is_div && !bus.op[0] && bus.a == {1'b1, {(W-1){1'b0}}} && &bus.b;
    early = EARLY_OUT != 0 && (zero || ovf);
    msum = (W+MUL_STEP)'(p[2*W-1:W]) + (W+MUL_STEP)'(m) * (W+MUL_STEP)'(p[MUL_STEP-1:0]);
    r2 = {p[2*W-1:W], p[W-1]};
    diff = r2 - {1'b0, m};
    // multiply retires multiplier bits from the low half; divide shifts quotient bits into it
    p_nx = op_r[2] ? (diff[W] ? {r2[W-1:0], p[W-2:0], 1'b0} : {diff[W-1:0], p[W-2:0], 1'b1})
                   : {msum, p[W-1:MUL_STEP]};
    prod = neg ? -p_nx : p_nx;
    dv = op_r[1] ? p_nx[2*W-1:W] : p_nx[W-1:0];
    fin = !op_r[2] ? (op_r[1:0] == 2'b00 ? prod[W-1:0] : prod[2*W-1:W])
                   : dz ? (op_r[1] ? a_r : '1) : (neg ? -dv : dv);
    last = cnt == CW'(op_r[2] ? W - 1 : W / MUL_STEP - 1);
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      ready <= 1'b0;
      busy <= 1'b0;
      result <= '0;
      div_by_zero <= 1'b0;
      cnt <= '0;
      op_r <= '0;
      a_r <= '0;
      m <= '0;
      p <= '0;
      neg <= 1'b0;
      dz <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.valid) begin
          op_r <= bus.op;
          a_r <= bus.a;
          m <= mb;
          p <= {{W{1'b0}}, ma};
          neg <= (is_div && bus.op[1]) ? sa : sa ^ sb;
          dz <= zero;
          cnt <= '0;
          busy <= 1'b1;
          if (early) begin
            state <= DONE;
            ready <= 1'b1;
            result <= zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
            div_by_zero <= zero;
          end else state <= CALC;
        end
        CALC: begin
          p <= p_nx;
          cnt <= cnt + CW'(1);
          if (last) begin
            state <= DONE;
            ready <= 1'b1;
            result <= fin;
            div_by_zero <= dz;
          end
        end
        DONE: begin
          ready <= 1'b0;
          busy <= 1'b0;
          cnt <= '0;
          state <= bus.valid ? HOLD : IDLE;
        end
        HOLD: if (!bus.valid) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table vectors, random ops against an arithmetic reference, and handshake/reset sequences.
module tb_muldiv_seq;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  muldiv_seq_if #(.WIDTH(32)) b0();
  muldiv_seq_if #(.WIDTH(32)) b1();
  muldiv_seq #(.WIDTH(32), .MUL_STEP(1), .EARLY_OUT(1)) dut0(.clk(clk), .resetn(resetn), .bus(b0));
  muldiv_seq #(.WIDTH(32), .MUL_STEP(4), .EARLY_OUT(0)) dut1(.clk(clk), .resetn(resetn), .bus(b1));
  typedef struct {
    int sel;
    logic [2:0] op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] r;
    logic dz;
    int lat;
  } vec_t;
  vec_t tbl[$];
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic drive(input int sel, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (sel == 0) begin
      b0.valid = v; b0.op = op; b0.a = a; b0.b = b;
    end else begin
      b1.valid = v; b1.op = op; b1.a = a; b1.b = b;
    end
  endtask
  function automatic logic rdy(input int sel);
    return sel != 0 ? b1.ready : b0.ready;
  endfunction
  function automatic logic bsy(input int sel);
    return sel != 0 ? b1.busy : b0.busy;
  endfunction
  function automatic logic [31:0] res(input int sel);
    return sel != 0 ? b1.result : b0.result;
  endfunction
  function automatic logic dzv(input int sel);
    return sel != 0 ? b1.div_by_zero : b0.div_by_zero;
  endfunction
  // dut0: MUL_STEP=1 with early-out; dut1: MUL_STEP=4 without early-out
  function automatic void ref_op(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic dz, output int lat);
    logic signed [63:0] s, sa64, sb64, ub64;
    logic [63:0] u;
    logic signed [31:0] sa, sb;
    logic ovf;
    sa = a;
    sb = b;
    sa64 = sa;
    sb64 = sb;
    ub64 = {32'b0, b};
    dz = op[2] && b == 0;
    ovf = op[2] && !op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff;
    r = '0;
    case (op)
      3'd0: begin u = {32'b0, a} * {32'b0, b}; r = u[31:0]; end
      3'd1: begin s = sa64 * sb64; r = s[63:32]; end
      3'd2: begin s = sa64 * ub64; r = s[63:32]; end
      3'd3: begin u = {32'b0, a} * {32'b0, b}; r = u[63:32]; end
      3'd4: if (dz) r = '1; else if (ovf) r = a; else r = sa / sb;
      3'd5: if (dz) r = '1; else r = a / b;
      3'd6: if (dz) r = a; else if (ovf) r = '0; else r = sa % sb;
      default: if (dz) r = a; else r = a % b;
    endcase
    if (sel == 0 && (dz || ovf)) lat = 1;
    else lat = op[2] ? 33 : (sel == 0 ? 33 : 9);
  endfunction
  task automatic do_op(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit drop,
                       output logic [31:0] r, output logic dz, output int lat);
    @(negedge clk);
    drive(sel, 1'b1, op, a, b);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat == 1) drive(sel, !drop, 3'($urandom), $urandom, $urandom);
    end while (!rdy(sel) && lat < 100);
    r = res(sel);
    dz = dzv(sel);
    drive(sel, 1'b0, op, a, b);
  endtask
  task automatic run(input int sel, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit drop,
                     input logic [31:0] er, input logic edz, input int elat, input string tag);
    logic [31:0] r;
    logic dz;
    int lat;
    do_op(sel, op, a, b, drop, r, dz, lat);
    chk({tag, "_result"}, r, er);
    chk({tag, "_dz"}, 32'(dz), 32'(edz));
    chk({tag, "_latency"}, lat, elat);
    @(negedge clk);
    chk({tag, "_held"}, res(sel), er);
    chk({tag, "_ready_once"}, 32'(rdy(sel)), 0);
  endtask
  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction
  initial begin
    logic [31:0] er, ra, rb;
    logic edz;
    logic [2:0] op;
    int elat, pulses;
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] er, ra, rb;
    logic edz;
    logic [2:0] op;
    int elat, pulses;
    tbl.push_back('{0, 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 1'b0, 33});
    tbl.push_back('{1, 3'd0, 32'd7, 32'hffff_fffd, 32'hffff_ffeb, 1'b0, 9});
    tbl.push_back('{0, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33});
    tbl.push_back('{1, 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 9});
    tbl.push_back('{0, 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 1'b0, 33});
    tbl.push_back('{0, 3'd2, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 33});
    tbl.push_back('{0, 3'd4, 32'hffff_fff9, 32'd2, 32'hffff_fffd, 1'b0, 33});
    tbl.push_back('{0, 3'd6, 32'hffff_fff9, 32'd2, 32'hffff_ffff, 1'b0, 33});
    tbl.push_back('{0, 3'd5, 32'd100, 32'd7, 32'd14, 1'b0, 33});
    tbl.push_back('{0, 3'd7, 32'd100, 32'd7, 32'd2, 1'b0, 33});
    tbl.push_back('{0, 3'd5, 32'd55, 32'd0, 32'hffff_ffff, 1'b1, 1});
    tbl.push_back('{0, 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1'b0, 1});
    tbl.push_back('{0, 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1'b0, 1});
    tbl.push_back('{0, 3'd7, 32'd5, 32'd0, 32'd5, 1'b1, 1});
    tbl.push_back('{0, 3'd4, 32'hffff_fffb, 32'd0, 32'hffff_ffff, 1'b1, 1});
    tbl.push_back('{1, 3'd5, 32'd55, 32'd0, 32'hffff_ffff, 1'b1, 33});
    tbl.push_back('{1, 3'd4, 32'hffff_fffb, 32'd0, 32'hffff_ffff, 1'b1, 33});
    tbl.push_back('{1, 3'd6, 32'hffff_fffb, 32'd0, 32'hffff_fffb, 1'b1, 33});
    tbl.push_back('{1, 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000, 1'b0, 33});
    tbl.push_back('{1, 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'd0, 1'b0, 33});
    drive(0, 1'b0, 3'd0, 32'd0, 32'd0);
    drive(1, 1'b0, 3'd0, 32'd0, 32'd0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      chk("reset_ready", 32'(rdy(s)), 0);
      chk("reset_busy", 32'(bsy(s)), 0);
      chk("reset_result", res(s), 0);
      chk("reset_dz", 32'(dzv(s)), 0);
    end
    resetn = 1'b1;
    foreach (tbl[i]) run(tbl[i].sel, tbl[i].op, tbl[i].a, tbl[i].b, 1'b0, tbl[i].r, tbl[i].dz, tbl[i].lat,
                         $sformatf("vec%0d", i));
    run(0, 3'd4, 32'hffff_fff9, 32'd2, 1'b1, 32'hffff_fffd, 1'b0, 33, "drop_valid");
    for (int i = 0; i < 150; i++) begin
      op = 3'($urandom_range(0, 7));
      ra = rnd_val();
      rb = rnd_val();
      ref_op(i % 2, op, ra, rb, er, edz, elat);
      run(i % 2, op, ra, rb, $urandom_range(0, 3) == 0, er, edz, elat, $sformatf("rand%0d_op%0d", i, op));
    end
    // valid held across a whole divide and far beyond
    @(negedge clk);
    drive(0, 1'b1, 3'd5, 32'd100, 32'd7);
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (rdy(0)) pulses++;
    end
    chk("hold_pulses", pulses, 1);
    chk("hold_busy", 32'(bsy(0)), 0);
    chk("hold_result", res(0), 32'd14);
    drive(0, 1'b0, 3'd5, 32'd100, 32'd7);
    run(0, 3'd0, 32'd12, 32'd11, 1'b0, 32'd132, 1'b0, 33, "after_hold");
    // asynchronous reset in the middle of a divide
    @(negedge clk);
    drive(0, 1'b1, 3'd4, 32'h1234_5678, 32'd3);
    @(posedge clk);
    repeat (10) @(negedge clk);
    chk("midcalc_busy", 32'(bsy(0)), 1);
    drive(0, 1'b0, 3'd4, 32'h1234_5678, 32'd3);
    #2 resetn = 1'b0;
    #1;
    chk("async_rst_ready", 32'(rdy(0)), 0);
    chk("async_rst_busy", 32'(bsy(0)), 0);
    chk("async_rst_result", res(0), 0);
    chk("async_rst_dz", 32'(dzv(0)), 0);
    @(negedge clk);
    chk("rst_still_idle", 32'(bsy(0)), 0);
    resetn = 1'b1;
    run(0, 3'd0, 32'd7, 32'hffff_fffd, 1'b0, 32'hffff_ffeb, 1'b0, 33, "post_reset_mul");
    run(1, 3'd3, 32'hffff_ffff, 32'hffff_ffff, 1'b0, 32'hffff_fffe, 1'b0, 9, "post_reset_mulhu4");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand/result width; even, >= 8.
REQ-002 SHALL have parameter MUL_STEP, default 1, multiplier bits retired per cycle; one of 1/2/4; divides WIDTH.
REQ-003 SHALL have parameter EARLY_OUT, default 1; 1 = divide-by-zero and signed overflow complete without CALC.
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port valid  input  1  request; held high by controller until ready seen.
REQ-007 SHALL have port op  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-008 SHALL have port a  input  WIDTH  rs1 operand (multiplicand/dividend).
REQ-009 SHALL have port b  input  WIDTH  rs2 operand (multiplier/divisor).
REQ-010 SHALL have port ready  output  1  one-cycle pulse, result valid.
REQ-011 SHALL have port result  output  WIDTH  final result, held until next acceptance.
REQ-012 SHALL have port div_by_zero  output  1  divisor was zero on a DIV/DIVU/REM/REMU; held with result.
REQ-013 SHALL have port busy  output  1  high in CALC and DONE.

Function
REQ-014 SHALL implement states IDLE, CALC, DONE, HOLD.
REQ-015 SHALL accept a request only when valid=1 in IDLE; op, a, b captured at that edge; later input changes ignored until next acceptance.
REQ-016 IDLE -> CALC on acceptance; IDLE -> DONE on acceptance when EARLY_OUT=1 and case is div-by-zero or signed overflow.
REQ-017 CALC SHALL last exactly WIDTH/MUL_STEP cycles for multiply ops and WIDTH cycles for divide ops (radix-2 restoring, one quotient bit per cycle), tracked by a cycle counter.
REQ-018 CALC -> DONE after last iteration; ready=1 only in DONE (exactly one cycle).
REQ-019 DONE -> HOLD if valid=1, else IDLE; HOLD -> IDLE when valid=0; no new acceptance before returning to IDLE (held valid yields exactly one ready pulse).
REQ-020 valid deasserting during CALC SHALL NOT abort; operation completes, ready pulses, then DONE -> IDLE.
REQ-021 Latency: ready high N+1 cycles after accepting edge (N = CALC length); early-out: ready high 1 cycle after accepting edge.
REQ-022 Multiply SHALL form 2*WIDTH-bit product of operands extended per op (MULH signed x signed, MULHSU signed x unsigned, MULHU/MUL unsigned semantics); MUL returns low WIDTH bits, others high WIDTH bits.
REQ-023 Signed divide SHALL operate on magnitudes and fix signs: quotient negative iff operand signs differ, remainder takes dividend sign.
REQ-024 Divisor zero: DIV/DIVU result all ones, REM/REMU result = a, div_by_zero=1; with EARLY_OUT=0 same values after full WIDTH CALC.
REQ-025 Signed overflow (a = 1 followed by WIDTH-1 zeros, b = all ones, DIV/REM): DIV result = a, REM result = 0, div_by_zero=0.
REQ-026 div_by_zero SHALL be 0 for multiply ops.

Reset
REQ-027 resetn=0 SHALL immediately force IDLE, ready=0, busy=0, result=0, div_by_zero=0, counter=0, regardless of state.
REQ-028 After resetn release, first acceptance no earlier than first rising edge with resetn=1.

Verification
REQ-029 WIDTH=32, MUL_STEP=1: MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, ready 33 cycles after accept; repeat MUL_STEP=4 -> ready after 9 cycles.
REQ-030 MULH a=b=0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
REQ-031 DIV a=0xFFFFFFF9 (-7), b=2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2; ready 33 cycles after accept.
REQ-032 DIVU b=0 -> 0xFFFFFFFF, div_by_zero=1, ready 1 cycle after accept (EARLY_OUT=1); REM a=0x80000000 b=0xFFFFFFFF -> 0, DIV -> 0x80000000.
REQ-033 valid held high 100 cycles over one DIV -> exactly one ready pulse, state HOLD until valid drops, next request accepted only after IDLE.
REQ-034 resetn pulled low mid-CALC (cycle 10 of DIV) -> ready/busy/result 0 asynchronously; fresh MUL after release produces correct result and latency.
